// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fault_code_t;

  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: next-PC input, imem req/ack, decode valid/ready and status outputs.
interface pc_fetch_unit_if;

  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    input  next_pc, imem_ack, imem_rdata, ir_ready,
    output imem_req, imem_addr, ir, ir_valid, pc, pc_plus4, fault, fault_code
  );

  modport slave (
    output next_pc, imem_ack, imem_rdata, ir_ready,
    input  imem_req, imem_addr, ir, ir_valid, pc, pc_plus4, fault, fault_code
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// 16-bit up-counter that flags the cycle in which it would reach a non-zero limit.
module fetch_timeout_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] limit_i,
  output logic        expired_o
);

  logic [15:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  // Expiry is raised on the increment that lands on the limit, so a limit of N
  // ends the wait after exactly N enabled cycles.
  assign expired_o = en_i && !clr_i && (limit_i != 16'd0) && (cnt_inc == limit_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer with misalign and timeout faults.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  pc_fetch_unit_if.master bus
);

  localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];

  fetch_state_t state_q, state_d;
  fault_code_t  fault_code_q, fault_code_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         ack_take, hs_done, misaligned;
  logic         tmo_clr, tmo_en, tmo_expired;

  assign ack_take   = (state_q == REQ) && bus.imem_ack;
  assign hs_done    = (state_q == HOLD) && bus.ir_ready;
  assign misaligned = (bus.next_pc[1:0] != 2'b00);
  assign tmo_en     = (state_q == REQ);
  assign tmo_clr    = (state_q != REQ) || bus.imem_ack;

  fetch_timeout_counter u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .limit_i   (TIMEOUT_LIMIT),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.imem_ack) begin
          state_d = HOLD;
        end else if (tmo_expired) begin
          state_d = FAULT;
        end
      end
      HOLD: begin
        if (bus.ir_ready) begin
          state_d = misaligned ? FAULT : REQ;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req = (state_q == REQ);
    bus.ir_valid = (state_q == HOLD);
    bus.fault    = (state_q == FAULT);
  end

  // FAULT is terminal, so the first code written is never overwritten.
  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    fault_code_d = fault_code_q;
    if (ack_take) begin
      ir_d = bus.imem_rdata;
    end
    if ((state_q == REQ) && !bus.imem_ack && tmo_expired) begin
      fault_code_d = FC_TIMEOUT;
    end
    if (hs_done) begin
      if (misaligned) begin
        fault_code_d = FC_MISALIGN;
      end else begin
        pc_d = bus.next_pc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q         <= RESET_VECTOR;
      ir_q         <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + PC_INCR;
  assign bus.ir         = ir_q;
  assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: fetched words are queued and checked at decode acceptance.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_ir_q[$];

  pc_fetch_unit_if ifa ();
  pc_fetch_unit_if ifb ();

  pc_fetch_unit #(.RESET_VECTOR(32'h100), .TIMEOUT_CYCLES(3)) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (ifa.master)
  );

  pc_fetch_unit #(.RESET_VECTOR(32'h100), .TIMEOUT_CYCLES(0)) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    ifa.pc, 32'h100);
    chk({tag, "_addr"},  ifa.imem_addr, 32'h100);
    chk({tag, "_ir"},    ifa.ir, 32'h0);
    chk({tag, "_irv"},   32'(ifa.ir_valid), 32'd0);
    chk({tag, "_req"},   32'(ifa.imem_req), 32'd0);
    chk({tag, "_fault"}, 32'(ifa.fault), 32'd0);
    chk({tag, "_code"},  32'(ifa.fault_code), 32'd0);
  endtask

  // Decode-side acceptance: every completed handshake must present the oldest queued word.
  always @(negedge clk) begin
    if (ifa.ir_valid === 1'b1 && ifa.ir_ready === 1'b1) begin
      if (exp_ir_q.size() == 0) begin
        chk("sb_nonempty", 32'(exp_ir_q.size()), 32'd1);
      end else begin
        chk("sb_ir", ifa.ir, exp_ir_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.next_pc = '0; ifa.imem_ack = 1'b0; ifa.imem_rdata = '0; ifa.ir_ready = 1'b0;
    ifb.next_pc = '0; ifb.imem_ack = 1'b0; ifb.imem_rdata = '0; ifb.ir_ready = 1'b0;

    repeat (2) cyc();
    @(negedge clk);
    chk_reset_state("rst");

    // IDLE cycle after release, then REQ with immediate ACK
    cyc(); rst_a = 1'b0;
    @(negedge clk);
    chk("idle_req", 32'(ifa.imem_req), 32'd0);
    cyc();
    ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'h0000_0013; exp_ir_q.push_back(32'h0000_0013);
    @(negedge clk);
    chk("req1_req", 32'(ifa.imem_req), 32'd1);
    chk("req1_addr", ifa.imem_addr, 32'h100);
    cyc(); ifa.imem_ack = 1'b0;
    @(negedge clk);
    chk("hold_ir", ifa.ir, 32'h13);
    chk("hold_irv", 32'(ifa.ir_valid), 32'd1);
    chk("hold_req", 32'(ifa.imem_req), 32'd0);
    chk("hold_pc4", ifa.pc_plus4, 32'h104);

    // Decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("stall_pc", ifa.pc, 32'h100);
      chk("stall_ir", ifa.ir, 32'h13);
      chk("stall_irv", 32'(ifa.ir_valid), 32'd1);
    end
    cyc(); ifa.ir_ready = 1'b1; ifa.next_pc = 32'h200;
    @(negedge clk);
    cyc(); ifa.ir_ready = 1'b0;
    ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'h0000_0093; exp_ir_q.push_back(32'h0000_0093);
    @(negedge clk);
    chk("jmp_pc", ifa.pc, 32'h200);
    chk("jmp_req", 32'(ifa.imem_req), 32'd1);
    chk("jmp_irv", 32'(ifa.ir_valid), 32'd0);

    // ACK while holding must not touch IR
    cyc(); ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("hold2_ir", ifa.ir, 32'h93);
    cyc(); ifa.imem_ack = 1'b0;
    @(negedge clk);
    chk("ack_ignored_ir", ifa.ir, 32'h93);
    chk("ack_ignored_irv", 32'(ifa.ir_valid), 32'd1);

    // Wrap of PC + 4
    cyc(); ifa.ir_ready = 1'b1; ifa.next_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    cyc(); ifa.ir_ready = 1'b0;
    ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'h0000_0033; exp_ir_q.push_back(32'h0000_0033);
    @(negedge clk);
    chk("wrap_pc", ifa.pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", ifa.pc_plus4, 32'h0);

    // Misaligned target
    cyc(); ifa.imem_ack = 1'b0; ifa.ir_ready = 1'b1; ifa.next_pc = 32'h202;
    @(negedge clk);
    chk("mis_pre_irv", 32'(ifa.ir_valid), 32'd1);
    cyc(); ifa.ir_ready = 1'b0;
    @(negedge clk);
    chk("mis_pc", ifa.pc, 32'hFFFF_FFFC);
    chk("mis_fault", 32'(ifa.fault), 32'd1);
    chk("mis_code", 32'(ifa.fault_code), 32'd1);
    chk("mis_req", 32'(ifa.imem_req), 32'd0);
    chk("mis_irv", 32'(ifa.ir_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      ifa.imem_ack = 1'b1; ifa.imem_rdata = $urandom;
      ifa.ir_ready = 1'b1; ifa.next_pc = $urandom;
      @(negedge clk);
      chk("flt_req", 32'(ifa.imem_req), 32'd0);
      chk("flt_fault", 32'(ifa.fault), 32'd1);
      chk("flt_code", 32'(ifa.fault_code), 32'd1);
      chk("flt_ir", ifa.ir, 32'h33);
      chk("flt_pc", ifa.pc, 32'hFFFF_FFFC);
    end

    // Reset clears the fault
    cyc(); ifa.imem_ack = 1'b0; ifa.ir_ready = 1'b0; rst_a = 1'b1;
    @(negedge clk);
    chk_reset_state("rst2");
    cyc(); rst_a = 1'b0;
    cyc();
    // Reset lands together with an ACK in REQ: the ACK must be dropped
    ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'hCAFE_F00D; rst_a = 1'b1;
    @(negedge clk);
    chk_reset_state("abort");
    cyc(); rst_a = 1'b0; ifa.imem_ack = 1'b0;
    @(negedge clk);
    chk("abort_idle_req", 32'(ifa.imem_req), 32'd0);
    chk("abort_ir", ifa.ir, 32'h0);

    // Timeout after three REQ cycles with no ACK
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("tmo_wait_req", 32'(ifa.imem_req), 32'd1);
      chk("tmo_wait_fault", 32'(ifa.fault), 32'd0);
    end
    cyc();
    @(negedge clk);
    chk("tmo_fault", 32'(ifa.fault), 32'd1);
    chk("tmo_code", 32'(ifa.fault_code), 32'd2);
    chk("tmo_req", 32'(ifa.imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); ifa.ir_ready = 1'b1; ifa.next_pc = 32'h3;
      @(negedge clk);
      chk("tmo_sticky_code", 32'(ifa.fault_code), 32'd2);
    end
    ifa.ir_ready = 1'b0;

    // Timeout disabled: a long wait never faults
    cyc(); rst_b = 1'b0;
    repeat (1001) cyc();
    @(negedge clk);
    chk("notmo_req", 32'(ifb.imem_req), 32'd1);
    chk("notmo_fault", 32'(ifb.fault), 32'd0);
    chk("notmo_code", 32'(ifb.fault_code), 32'd0);
    chk("notmo_pc", ifb.pc, 32'h100);

    chk("sb_empty", 32'(exp_ir_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
